dccm: RTL and testbench

Data closely-coupled memory: the responder end of the LSU DCCM interface. It holds a word-addressed synchronous data array and accepts one read and one write per cycle. Reads return data after a fixed one-cycle latency, which is what the LSU DC2 stage expects. An optional power-on zero-initialisation sequencer gates the block's readiness.

---
 rtl/dccm.sv | 131 +++++++++++++
 tb/tb_dccm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dccm.sv
// Data closely-coupled memory: word-addressed synchronous array
// serving one read and one write per cycle, with optional zero-init.
module dccm #(
  parameter int unsigned          XLEN        = 32,
  parameter int unsigned          DEPTH_WORDS = 16384,
  parameter logic [XLEN-1:0]      BASE_ADDR   = '0,
  parameter bit                   ZERO_INIT   = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  output logic            dccm_ready,
  output logic            dccm_addr_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic [XLEN-1:0] rdata_q;
  logic            rvalid_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [XLEN-1:0] roff, woff;
  logic            rin, win;
  logic [AW-1:0]   ridx, widx;
  logic            run;

  logic            we;
  logic [AW-1:0]   we_idx;
  logic [XLEN-1:0] we_data;

  // Offset from the window base; the full-width compare rejects
  // addresses below the base too, since they wrap to large offsets.
  always_comb begin
    roff = lsu_dccm_raddr - BASE_ADDR;
    woff = lsu_dccm_waddr - BASE_ADDR;
    rin  = ({1'b0, roff} < SPAN);
    win  = ({1'b0, woff} < SPAN);
    ridx = roff[AW+1:2];
    widx = woff[AW+1:2];
    run  = (state_q == RUN);
  end

  // State register and init counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ZERO_INIT ? INIT : RUN;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Next state: sweep every word once, then stay in RUN.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Single write port: the init sweep owns it until RUN.
  always_comb begin
    we      = 1'b0;
    we_idx  = widx;
    we_data = lsu_dccm_wdata;
    if (!run) begin
      we      = 1'b1;
      we_idx  = init_idx_q;
      we_data = '0;
    end else if (lsu_dccm_wen && win) begin
      we = 1'b1;
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[we_idx] <= we_data;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= run && lsu_dccm_rvalid_in;
      err_q    <= run && ((lsu_dccm_rvalid_in && !rin) ||
                          (lsu_dccm_wen && !win));
      if (run && lsu_dccm_rvalid_in) begin
        rdata_q <= rin ? mem[ridx] : '0;
      end
    end
  end

  assign lsu_dccm_rdata      = rdata_q;
  assign lsu_dccm_rvalid_out = rvalid_q;
  assign dccm_addr_err       = err_q;
  assign dccm_ready          = run;

endmodule

// File: tb/tb_dccm.sv
// Directed bench for dccm: init sweep, read/write, collisions,
// range errors, streaming and reset during init.
module tb_dccm;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] raddr;
  logic        rvin;
  logic [31:0] rdata;
  logic        rvout;
  logic [31:0] waddr;
  logic        wen;
  logic [31:0] wdata;
  logic        ready;
  logic        aerr;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb [16];

  dccm #(
    .XLEN       (32),
    .DEPTH_WORDS(16),
    .BASE_ADDR  (BASE),
    .ZERO_INIT  (1'b1)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .lsu_dccm_raddr     (raddr),
    .lsu_dccm_rvalid_in (rvin),
    .lsu_dccm_rdata     (rdata),
    .lsu_dccm_rvalid_out(rvout),
    .lsu_dccm_waddr     (waddr),
    .lsu_dccm_wen       (wen),
    .lsu_dccm_wdata     (wdata),
    .dccm_ready         (ready),
    .dccm_addr_err      (aerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rvin = 1'b0;
    wen  = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    raddr = '0;
    rvin  = 1'b0;
    waddr = '0;
    wen   = 1'b0;
    wdata = '0;
    #3;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvout), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(aerr), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Init sweep: LSU traffic must be ignored throughout.
    for (int i = 1; i <= 16; i++) begin
      wen   = 1'b1;
      waddr = BASE + 32'h14;
      wdata = 32'h1234;
      rvin  = 1'b1;
      raddr = BASE + 32'h100;
      tick();
      chk("init_ready", 32'(ready), (i == 16) ? 32'd1 : 32'd0);
      chk("init_rvalid", 32'(rvout), 32'd0);
      chk("init_err", 32'(aerr), 32'd0);
    end
    for (int i = 0; i < 16; i++) sb[i] = '0;

    // First RUN cycle request is serviced; dropped init write reads 0.
    wen   = 1'b0;
    rvin  = 1'b1;
    raddr = BASE + 32'h14;
    tick();
    chk("first_rvalid", 32'(rvout), 32'd1);
    chk("drop_write", rdata, 32'd0);

    // Basic write then read.
    idle();
    wen   = 1'b1;
    waddr = BASE + 32'h8;
    wdata = 32'hDEADBEEF;
    tick();
    sb[2] = 32'hDEADBEEF;
    chk("wr_rvalid", 32'(rvout), 32'd0);
    chk("wr_hold", rdata, 32'd0);
    idle();
    rvin  = 1'b1;
    raddr = BASE + 32'h8;
    tick();
    chk("rd_rvalid", 32'(rvout), 32'd1);
    chk("rd_data", rdata, 32'hDEADBEEF);
    raddr = BASE + 32'hB;
    tick();
    chk("rd_lowbits", rdata, 32'hDEADBEEF);
    chk("rd_noerr", 32'(aerr), 32'd0);

    // Same-cycle collision returns old data.
    idle();
    wen   = 1'b1;
    waddr = BASE + 32'hC;
    wdata = 32'h11111111;
    tick();
    wdata = 32'h22222222;
    rvin  = 1'b1;
    raddr = BASE + 32'hC;
    tick();
    chk("coll_old", rdata, 32'h11111111);
    wen = 1'b0;
    tick();
    chk("coll_new", rdata, 32'h22222222);
    sb[3] = 32'h22222222;

    // Out-of-range read.
    idle();
    rvin  = 1'b1;
    raddr = BASE + 32'h40;
    tick();
    chk("oor_rvalid", 32'(rvout), 32'd1);
    chk("oor_rdata", rdata, 32'd0);
    chk("oor_err", 32'(aerr), 32'd1);
    idle();
    tick();
    chk("oor_pulse", 32'(aerr), 32'd0);
    chk("oor_idle_rv", 32'(rvout), 32'd0);

    // Out-of-range writes: above the window and wrapping below it.
    wen   = 1'b1;
    waddr = BASE + 32'h40;
    wdata = 32'hFFFF_FFFF;
    tick();
    chk("oorw_err", 32'(aerr), 32'd1);
    waddr = BASE - 32'h4;
    tick();
    chk("oorw_wrap_err", 32'(aerr), 32'd1);
    idle();
    tick();
    chk("oorw_pulse", 32'(aerr), 32'd0);

    // Simultaneous read and write errors: one pulse.
    wen   = 1'b1;
    waddr = BASE + 32'h80;
    rvin  = 1'b1;
    raddr = BASE + 32'h44;
    tick();
    chk("both_err", 32'(aerr), 32'd1);
    chk("both_rdata", rdata, 32'd0);
    idle();
    tick();
    chk("both_pulse", 32'(aerr), 32'd0);

    // Streaming reads with colliding writes of idx^0xA5.
    for (int i = 0; i < 16; i++) begin
      rvin  = 1'b1;
      raddr = BASE + 32'(i * 4);
      wen   = 1'b1;
      waddr = BASE + 32'(i * 4);
      wdata = 32'(i) ^ 32'hA5;
      tick();
      chk("strm_rvalid", 32'(rvout), 32'd1);
      chk("strm_data", rdata, sb[i]);
      sb[i] = 32'(i) ^ 32'hA5;
    end
    wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rvin  = 1'b1;
      raddr = BASE + 32'(i * 4);
      tick();
      chk("strm2_rvalid", 32'(rvout), 32'd1);
      chk("strm2_data", rdata, sb[i]);
    end

    // Asynchronous reset while outputs are live.
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvout), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_err", 32'(aerr), 32'd0);
    idle();
    rstn = 1'b1;

    // Reset again at init_idx=7; sweep must restart from zero.
    for (int i = 0; i < 7; i++) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_rvalid", 32'(rvout), 32'd0);
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("reinit_ready", 32'(ready), (i == 16) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      rvin  = 1'b1;
      raddr = BASE + 32'(i * 4);
      tick();
      chk("reinit_rvalid", 32'(rvout), 32'd1);
      chk("reinit_zero", rdata, 32'd0);
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
